// File: rtl/cl_mult_rr_sched.sv
// rtl/cl_mult_rr_sched.sv - round-robin scheduler sharing one pipelined carry-less multiplier
module cl_mult_rr_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 4,
  parameter int ID_W       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_a,
  input  logic [NREQ*DATA_WIDTH-1:0] req_b,
  output logic [NREQ-1:0]            req_ready,
  output logic                       mult_enable,
  output logic [DATA_WIDTH-1:0]      mult_a,
  output logic [DATA_WIDTH-1:0]      mult_b,
  input  logic [2*DATA_WIDTH-1:0]    mult_result,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [2*DATA_WIDTH-1:0]    rsp_result,
  output logic                       busy,
  output logic [31:0]                ops_done
);

  // One extra bit so rr_ptr + offset cannot overflow before the modulo fold.
  localparam int               CW      = ID_W + 1;
  localparam logic [CW-1:0]    NREQ_C  = CW'(NREQ);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NREQ - 1);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            issue;

  // Tag pipeline: stage 0 tracks the multiplier input register, stage 1 its output register.
  logic            v0;
  logic            v1;
  logic [ID_W-1:0] t0;
  logic [ID_W-1:0] t1;

  // Scan requesters starting at rr_ptr and pick the first one holding valid.
  always_comb begin
    logic [CW-1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= NREQ_C) begin
        cand = cand - NREQ_C;
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Grant is suppressed during reset; an issue is simply a grant to a valid requester.
  always_comb begin
    issue     = grant_found & ~rst;
    req_ready = '0;
    if (issue) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Operands are forced to zero when idle so the multiplier computes a harmless 0.
  always_comb begin
    mult_enable = ~rst;
    mult_a      = '0;
    mult_b      = '0;
    if (issue) begin
      mult_a = req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      mult_b = req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Response side is gated by the stage-1 tag so idle products never leak out.
  always_comb begin
    rsp_valid  = v1;
    rsp_id     = v1 ? t1 : '0;
    rsp_result = v1 ? mult_result : '0;
    busy       = v0 | v1;
  end

  // Pointer, tag pipeline and delivered-response counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      t0       <= '0;
      t1       <= '0;
      ops_done <= '0;
    end else begin
      if (issue) begin
        rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
      end
      v0 <= issue;
      t0 <= grant_idx;
      v1 <= v0;
      t1 <= t0;
      if (v1) begin
        ops_done <= ops_done + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cl_mult_rr_sched.sv
// tb/tb_cl_mult_rr_sched.sv - directed-vector bench for cl_mult_rr_sched
module tb_cl_mult_rr_sched;

  localparam int DW   = 32;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_a;
  logic [NREQ*DW-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 mult_enable;
  logic [DW-1:0]        mult_a;
  logic [DW-1:0]        mult_b;
  logic [2*DW-1:0]      mult_result;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [2*DW-1:0]      rsp_result;
  logic                 busy;
  logic [31:0]          ops_done;

  int n_vec = 0;
  int n_err = 0;

  cl_mult_rr_sched #(.DATA_WIDTH(DW), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mult_enable(mult_enable), .mult_a(mult_a), .mult_b(mult_b), .mult_result(mult_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .busy(busy), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiplier: input register then output register, cleared while enable is low.
  function automatic logic [2*DW-1:0] clmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i++) begin
      if (b[i]) r = r ^ ({{DW{1'b0}}, a} << i);
    end
    return r;
  endfunction

  logic [DW-1:0]   ma_r;
  logic [DW-1:0]   mb_r;
  logic [2*DW-1:0] prod_r;

  always_ff @(posedge clk) begin
    if (!mult_enable) begin
      ma_r   <= '0;
      mb_r   <= '0;
      prod_r <= '0;
    end else begin
      ma_r   <= mult_a;
      mb_r   <= mult_b;
      prod_r <= clmul(ma_r, mb_r);
    end
  end
  assign mult_result = prod_r;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h1234_5678, 32'h0F0F_0F0F);
    req_valid = 4'hF;
    next_cycle();
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    n_vec++; if (mult_enable !== 1'b0) begin n_err++; $display("FAIL rst_enable got=%b exp=0", mult_enable); end
    n_vec++; if (mult_a !== '0 || mult_b !== '0) begin n_err++; $display("FAIL rst_operands got=%h/%h exp=0/0", mult_a, mult_b); end
    n_vec++; if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_result !== '0) begin n_err++; $display("FAIL rst_rsp got=%b/%0d/%h exp=0/0/0", rsp_valid, rsp_id, rsp_result); end
    n_vec++; if (busy !== 1'b0 || ops_done !== 32'd0) begin n_err++; $display("FAIL rst_busy_ops got=%b/%0d exp=0/0", busy, ops_done); end
    next_cycle();
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single;
    do_reset();
    set_op(0, 32'h3, 32'h3);
    req_valid = 4'b0001;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL t1_ready got=%b exp=0001", req_ready); end
    n_vec++; if (mult_a !== 32'h3 || mult_b !== 32'h3) begin n_err++; $display("FAIL t1_operands got=%h/%h exp=3/3", mult_a, mult_b); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t1_busy_c0 got=%b exp=0", busy); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL t1_c1 got valid=%b busy=%b exp 0/1", rsp_valid, busy); end
    next_cycle();
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 64'h5) begin n_err++; $display("FAIL t1_rsp got=%b/%0d/%h exp=1/0/5", rsp_valid, rsp_id, rsp_result); end
    next_cycle();
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0 || rsp_result !== '0 || busy !== 1'b0 || ops_done !== 32'd1) begin n_err++; $display("FAIL t1_after got=%b/%h/%b/%0d exp=0/0/0/1", rsp_valid, rsp_result, busy, ops_done); end
  endtask

  task automatic test_rotate_all;
    logic [3:0] exp_r;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h7, 32'h5);
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (c < 8) begin
        exp_r = 4'b0001 << (c % 4);
        n_vec++; if (req_ready !== exp_r) begin n_err++; $display("FAIL t2_ready c=%0d got=%b exp=%b", c, req_ready, exp_r); end
      end
      if (c >= 2 && c < 10) begin
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4) || rsp_result !== 64'h1B) begin
          n_err++; $display("FAIL t2_rsp c=%0d got=%b/%0d/%h exp=1/%0d/1b", c, rsp_valid, rsp_id, rsp_result, (c - 2) % 4);
        end
      end
      if (c == 10) begin
        n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 32'd8) begin n_err++; $display("FAIL t2_done got=%b/%b/%0d exp=0/0/8", rsp_valid, busy, ops_done); end
      end
      next_cycle();
    end
  endtask

  task automatic test_pointer;
    logic [3:0]      vld [5]  = '{4'b0010, 4'b1001, 4'b0001, 4'b0000, 4'b0000};
    logic [3:0]      rdy [5]  = '{4'b0010, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
    logic [1:0]      ids [3]  = '{2'd1, 2'd3, 2'd0};
    logic [2*DW-1:0] res [3]  = '{64'h6, 64'hF, 64'h14};
    do_reset();
    set_op(0, 32'h6, 32'h6);
    set_op(1, 32'h2, 32'h3);
    set_op(3, 32'h5, 32'h3);
    for (int c = 0; c < 5; c++) begin
      req_valid = vld[c];
      @(negedge clk);
      n_vec++; if (req_ready !== rdy[c]) begin n_err++; $display("FAIL t3_ready c=%0d got=%b exp=%b", c, req_ready, rdy[c]); end
      if (c >= 2) begin
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== ids[c-2] || rsp_result !== res[c-2]) begin
          n_err++; $display("FAIL t3_rsp c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, rsp_valid, rsp_id, rsp_result, ids[c-2], res[c-2]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight;
    do_reset();
    set_op(0, 32'h3, 32'h3);
    set_op(1, 32'h7, 32'h5);
    req_valid = 4'b0011;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL t4_issue0 got=%b exp=0001", req_ready); end
    next_cycle();
    req_valid = 4'b0010;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL t4_issue1 got=%b exp=0010", req_ready); end
    next_cycle();
    rst = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0000 || mult_enable !== 1'b0 || mult_a !== '0) begin n_err++; $display("FAIL t4_in_rst got=%b/%b/%h exp=0000/0/0", req_ready, mult_enable, mult_a); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 32'd0) begin n_err++; $display("FAIL t4_after got=%b/%b/%0d exp=0/0/0", rsp_valid, busy, ops_done); end
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL t4_ptr got=%b exp=0001", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL t4_no_rsp got=%b exp=0", rsp_valid); end
    next_cycle();
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 64'h5) begin n_err++; $display("FAIL t4_new_rsp got=%b/%0d/%h exp=1/0/5", rsp_valid, rsp_id, rsp_result); end
    next_cycle();
  endtask

  task automatic test_max_operands;
    do_reset();
    set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b0100;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL t5_ready got=%b exp=0100", req_ready); end
    next_cycle();
    req_valid = '0;
    next_cycle();
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 64'h5555_5555_5555_5555) begin n_err++; $display("FAIL t5_rsp got=%b/%0d/%h exp=1/2/5555555555555555", rsp_valid, rsp_id, rsp_result); end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    set_op(1, 32'h9, 32'h2);
    for (int c = 0; c <= 7; c++) begin
      req_valid = (c < 5) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (c < 5) begin
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL t6_ready c=%0d got=%b exp=0010", c, req_ready); end
      end
      if (c >= 2 && c < 7) begin
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 64'h12) begin n_err++; $display("FAIL t6_rsp c=%0d got=%b/%0d/%h exp=1/1/12", c, rsp_valid, rsp_id, rsp_result); end
      end
      if (c == 7) begin
        n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 32'd6) begin n_err++; $display("FAIL t6_done got=%b/%b/%0d exp=0/0/6", rsp_valid, busy, ops_done); end
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    #1;
    test_reset();
    test_single();
    test_rotate_all();
    test_pointer();
    test_reset_midflight();
    test_max_operands();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
